// File: rtl/hamming_pkg.sv
// Shared Hamming(12,8) definitions: code geometry plus the syndrome,
// extract and encode helpers used by both the encoder and the decoder.
package hamming_pkg;

  localparam int DATA_W = 8;
  localparam int CW_W   = 12;

  // Hamming position (1-based) of each data bit d0..d7.
  localparam int DATA_POS [0:DATA_W-1] = '{3, 5, 6, 7, 9, 10, 11, 12};

  // Bit k of the syndrome is the even parity over every position whose
  // index has bit k set, parity positions included.
  function automatic logic [3:0] calc_syndrome(input logic [CW_W-1:0] cw);
    logic [3:0] s;
    s = '0;
    for (int pos = 1; pos <= CW_W; pos++) begin
      for (int k = 0; k < 4; k++) begin
        if (pos[k]) begin
          s[k] = s[k] ^ cw[pos-1];
        end
      end
    end
    return s;
  endfunction

  // Gathers d0..d7 from their code positions.
  function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < DATA_W; i++) begin
      d[i] = cw[DATA_POS[i]-1];
    end
    return d;
  endfunction

  // With the parity positions still zero, the syndrome of the data-only
  // word is exactly the parity needed at positions 1, 2, 4 and 8.
  function automatic logic [CW_W-1:0] encode_data(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0] cw;
    logic [3:0]      p;
    cw = '0;
    for (int i = 0; i < DATA_W; i++) begin
      cw[DATA_POS[i]-1] = d[i];
    end
    p     = calc_syndrome(cw);
    cw[0] = p[0];
    cw[1] = p[1];
    cw[3] = p[2];
    cw[7] = p[3];
    return cw;
  endfunction

endpackage

// File: rtl/hamming_decoder_12to8_pipe_correct.sv
// Combinational single-error correction for one Hamming(12,8) codeword.
// The syndrome is computed upstream with calc_syndrome and arrives already
// registered, so this block only flips, extracts and raises the flags.
module hamming_correct_12
  import hamming_pkg::*;
(
  input  logic [CW_W-1:0]   codeword,
  input  logic [3:0]        syndrome,
  output logic [DATA_W-1:0] data,
  output logic              corrected,
  output logic              uncorrectable
);

  logic [CW_W-1:0] fixed;

  // Flip the position named by a 1..12 syndrome; 13..15 cannot be a single error.
  always_comb begin
    fixed         = codeword;
    corrected     = 1'b0;
    uncorrectable = 1'b0;
    if (syndrome >= 4'd13) begin
      uncorrectable = 1'b1;
    end else if (syndrome != 4'd0) begin
      corrected = 1'b1;
      for (int p = 1; p <= CW_W; p++) begin
        if (syndrome == p[3:0]) begin
          fixed[p-1] = ~codeword[p-1];
        end
      end
    end
    data = extract_data(fixed);
  end

endmodule

// File: rtl/hamming_decoder_12to8_pipe.sv
// Two-stage Hamming(12,8) SEC decoder with valid/ready on both sides and
// saturating corrected/uncorrectable beat counters.
module hamming_decoder_12to8_pipe
  import hamming_pkg::*;
#(
  parameter int COUNT_W = 16
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CW_W-1:0]    in_codeword,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_corrected,
  output logic               out_uncorrectable,
  output logic [3:0]         out_syndrome,
  input  logic               clr_counters,
  output logic [COUNT_W-1:0] cnt_corrected,
  output logic [COUNT_W-1:0] cnt_uncorrectable
);

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  logic              adv;
  logic              s1_valid;
  logic [CW_W-1:0]   s1_codeword;
  logic [3:0]        s1_syndrome;
  logic [DATA_W-1:0] fix_data;
  logic              fix_corrected;
  logic              fix_uncorrectable;
  logic              s1_moves;

  // The whole pipe advances together whenever the output slot is free or draining.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign s1_moves = adv && s1_valid;

  hamming_correct_12 u_correct (
    .codeword      (s1_codeword),
    .syndrome      (s1_syndrome),
    .data          (fix_data),
    .corrected     (fix_corrected),
    .uncorrectable (fix_uncorrectable)
  );

  // Stage 1: capture the incoming codeword together with its syndrome.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_codeword <= '0;
      s1_syndrome <= '0;
    end else if (adv) begin
      s1_valid    <= in_valid;
      s1_codeword <= in_codeword;
      s1_syndrome <= calc_syndrome(in_codeword);
    end
  end

  // Stage 2: register corrected data and flags; bubbles load zeros so idle outputs read 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_corrected     <= 1'b0;
      out_uncorrectable <= 1'b0;
      out_syndrome      <= '0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data          <= fix_data;
        out_corrected     <= fix_corrected;
        out_uncorrectable <= fix_uncorrectable;
        out_syndrome      <= s1_syndrome;
      end else begin
        out_data          <= '0;
        out_corrected     <= 1'b0;
        out_uncorrectable <= 1'b0;
        out_syndrome      <= '0;
      end
    end
  end

  // Count corrected beats as they enter stage 2; clear beats a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_corrected <= '0;
    end else if (clr_counters) begin
      cnt_corrected <= '0;
    end else if (s1_moves && fix_corrected && (cnt_corrected != CNT_MAX)) begin
      cnt_corrected <= cnt_corrected + 1'b1;
    end
  end

  // Count uncorrectable beats the same way, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_uncorrectable <= '0;
    end else if (clr_counters) begin
      cnt_uncorrectable <= '0;
    end else if (s1_moves && fix_uncorrectable && (cnt_uncorrectable != CNT_MAX)) begin
      cnt_uncorrectable <= cnt_uncorrectable + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_decoder_12to8_pipe.sv
// Scoreboard bench for the pipelined Hamming(12,8) decoder: directed vectors,
// a backpressure stall, reset with beats in flight, counter saturation and a
// random-ready stream checked against a bench encoder model.
module tb_hamming_decoder_12to8_pipe;

  localparam int COUNT_W = 2;

  typedef struct {
    logic [7:0] data;
    logic       corr;
    logic       unc;
    logic [3:0] syn;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [11:0]        in_codeword;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         out_data;
  logic               out_corrected;
  logic               out_uncorrectable;
  logic [3:0]         out_syndrome;
  logic               clr_counters;
  logic [COUNT_W-1:0] cnt_corrected;
  logic [COUNT_W-1:0] cnt_uncorrectable;

  exp_t exp_q[$];
  exp_t mon_exp;
  int   checks_total  = 0;
  int   checks_passed = 0;
  bit   random_done   = 1'b0;
  int   data_pos [8]  = '{3, 5, 6, 7, 9, 10, 11, 12};

  hamming_decoder_12to8_pipe #(.COUNT_W(COUNT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_codeword       (in_codeword),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_corrected     (out_corrected),
    .out_uncorrectable (out_uncorrectable),
    .out_syndrome      (out_syndrome),
    .clr_counters      (clr_counters),
    .cnt_corrected     (cnt_corrected),
    .cnt_uncorrectable (cnt_uncorrectable)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [7:0] d, input logic c, input logic u, input logic [3:0] s);
    exp_t e;
    e.data = d;
    e.corr = c;
    e.unc  = u;
    e.syn  = s;
    return e;
  endfunction

  function automatic void checkOutput(input string name, input int unsigned act, input int unsigned want);
    checks_total++;
    if (act == want) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
  endfunction

  function automatic void failCheck(input string name);
    checks_total++;
    $display("[TB] FAIL %s: got timeout, expected completion", name);
  endfunction

  // Reference encoder: place data, then set each parity bit to even parity over its group.
  function automatic logic [11:0] model_encode(input logic [7:0] d);
    logic [11:0] cw;
    logic        p;
    cw = '0;
    for (int i = 0; i < 8; i++) cw[data_pos[i]-1] = d[i];
    for (int k = 0; k < 4; k++) begin
      p = 1'b0;
      for (int pos = 1; pos <= 12; pos++) begin
        if (((pos >> k) & 1) != 0) p = p ^ cw[pos-1];
      end
      cw[(1 << k) - 1] = p;
    end
    return cw;
  endfunction

  // Present one beat, wait (bounded) for acceptance, then queue its expected result.
  task automatic applyStimulus(input logic [11:0] cw, input exp_t e);
    int  waited;
    bit  taken;
    waited = 0;
    taken  = 1'b0;
    in_codeword = cw;
    in_valid    = 1'b1;
    while (!taken && waited < 200) begin
      @(negedge clk);
      if (in_ready) taken = 1'b1;
      else waited++;
    end
    if (taken) exp_q.push_back(e);
    else failCheck("input accept");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (exp_q.size() != 0) begin
      failCheck("drain");
      exp_q.delete();
    end
  endtask

  task automatic pulse_clear();
    clr_counters = 1'b1;
    @(posedge clk);
    #1;
    clr_counters = 1'b0;
  endtask

  // Monitor: every transferred output beat is compared against the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks_total++;
        $display("[TB] FAIL unexpected beat: got data 0x%0h, expected no beat", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("out_data", out_data, mon_exp.data);
        checkOutput("out_corrected", out_corrected, mon_exp.corr);
        checkOutput("out_uncorrectable", out_uncorrectable, mon_exp.unc);
        checkOutput("out_syndrome", out_syndrome, mon_exp.syn);
      end
    end
  end

  task automatic backpressure_test();
    fork
      begin
        applyStimulus(12'hA78, mk(8'hAA, 1'b1, 1'b0, 4'd6));
        applyStimulus(12'hA58, mk(8'hAA, 1'b0, 1'b0, 4'd0));
        applyStimulus(12'hF77, mk(8'hFF, 1'b0, 1'b0, 4'd0));
        applyStimulus(12'h259, mk(8'h2A, 1'b0, 1'b1, 4'd13));
      end
      begin
        int w;
        w = 0;
        while (!out_valid && w < 50) begin
          @(posedge clk);
          #1;
          w++;
        end
        if (!out_valid) failCheck("stall first beat");
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          checkOutput("stall in_ready", in_ready, 0);
          checkOutput("stall out_valid", out_valid, 1);
          checkOutput("stall out_data", out_data, 8'hAA);
          checkOutput("stall out_syndrome", out_syndrome, 4'd6);
          checkOutput("stall out_corrected", out_corrected, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic random_test();
    random_done = 1'b0;
    fork
      begin
        logic [7:0]  d;
        logic [11:0] cw;
        int          pos;
        exp_t        e;
        for (int n = 0; n < 200; n++) begin
          d  = 8'($urandom);
          cw = model_encode(d);
          e  = mk(d, 1'b0, 1'b0, 4'd0);
          if ($urandom_range(0, 2) != 0) begin
            pos         = int'($urandom_range(1, 12));
            cw[pos-1]   = ~cw[pos-1];
            e.corr      = 1'b1;
            e.syn       = pos[3:0];
          end
          applyStimulus(cw, e);
        end
        random_done = 1'b1;
      end
      begin
        while (!random_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_codeword  = '0;
    out_ready    = 1'b1;
    clr_counters = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset out_data", out_data, 0);
    checkOutput("reset out_corrected", out_corrected, 0);
    checkOutput("reset out_uncorrectable", out_uncorrectable, 0);
    checkOutput("reset out_syndrome", out_syndrome, 0);
    checkOutput("reset cnt_corrected", cnt_corrected, 0);
    checkOutput("reset cnt_uncorrectable", cnt_uncorrectable, 0);
    rst = 1'b0;
    #1;
    checkOutput("in_ready after reset", in_ready, 1);
    @(posedge clk);
    #1;

    $display("[TB] directed vectors");
    applyStimulus(12'hA58, mk(8'hAA, 1'b0, 1'b0, 4'd0));
    checkOutput("latency out_valid after 1 edge", out_valid, 0);
    @(posedge clk);
    #1;
    checkOutput("latency out_valid after 2 edges", out_valid, 1);
    drain();
    applyStimulus(12'hF77, mk(8'hFF, 1'b0, 1'b0, 4'd0));
    drain();
    checkOutput("cnt_corrected clean", cnt_corrected, 0);
    applyStimulus(12'hA78, mk(8'hAA, 1'b1, 1'b0, 4'd6));
    drain();
    checkOutput("cnt_corrected data error", cnt_corrected, 1);
    applyStimulus(12'hA59, mk(8'hAA, 1'b1, 1'b0, 4'd1));
    drain();
    checkOutput("cnt_corrected parity error", cnt_corrected, 2);
    applyStimulus(12'h259, mk(8'h2A, 1'b0, 1'b1, 4'd13));
    drain();
    checkOutput("cnt_uncorrectable", cnt_uncorrectable, 1);
    checkOutput("cnt_corrected after uncorrectable", cnt_corrected, 2);

    $display("[TB] backpressure");
    backpressure_test();

    $display("[TB] reset with beats in flight");
    pulse_clear();
    applyStimulus(12'hA78, mk(8'hAA, 1'b1, 1'b0, 4'd6));
    applyStimulus(12'hA59, mk(8'hAA, 1'b1, 1'b0, 4'd1));
    checkOutput("pre-reset out_valid", out_valid, 1);
    checkOutput("pre-reset cnt_corrected", cnt_corrected, 1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("mid reset out_valid", out_valid, 0);
    checkOutput("mid reset out_data", out_data, 0);
    checkOutput("mid reset cnt_corrected", cnt_corrected, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("post reset in_ready", in_ready, 1);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("post reset no beat", out_valid, 0);

    $display("[TB] counter saturation and clear");
    for (int n = 0; n < 5; n++) begin
      applyStimulus(12'hA78, mk(8'hAA, 1'b1, 1'b0, 4'd6));
    end
    drain();
    checkOutput("cnt_corrected saturated", cnt_corrected, 3);
    applyStimulus(12'hA78, mk(8'hAA, 1'b1, 1'b0, 4'd6));
    clr_counters = 1'b1;
    @(posedge clk);
    #1;
    clr_counters = 1'b0;
    checkOutput("clear beats increment", cnt_corrected, 0);
    drain();

    $display("[TB] random out_ready stream");
    random_test();

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/hamming_decoder_12to8_pipe.md
Name: hamming_decoder_12to8_pipe

Overview:
Downstream consumer of hamming_encoder_8to12 codewords, typically read back from the dual-port memory. Computes the Hamming(12,8) syndrome, corrects any single-bit error, and flags uncorrectable syndromes. It is a 2-stage registered pipeline with valid/ready handshake on both sides. It also keeps saturating error statistics for software readout.

Parameters:
COUNT_W, 16, width of each saturating error counter (min 2)

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  codeword present on in_codeword
in_ready  out  1  decoder accepts a beat this cycle
in_codeword  in  12  codeword; bit i = Hamming position i+1
out_valid  out  1  decoded beat present
out_ready  in  1  downstream accepts the beat
out_data  out  8  decoded or corrected data byte
out_corrected  out  1  single-bit error was corrected in this beat
out_uncorrectable  out  1  syndrome 13..15; data is uncorrected
out_syndrome  out  4  raw syndrome of this beat
clr_counters  in  1  synchronous clear of both counters
cnt_corrected  out  COUNT_W  saturating count of corrected beats
cnt_uncorrectable  out  COUNT_W  saturating count of uncorrectable beats

Behaviour:
- Code layout (must match the encoder): parity bits at positions 1, 2, 4, 8.
  - Data bits: d0..d7 at positions 3, 5, 6, 7, 9, 10, 11, 12.
  - Even parity: p_k = XOR of all positions whose index has bit k set.
- Syndrome s[k] = XOR of all 12 received positions whose index has bit k set.
  - s = 0: clean.
  - s = 1..12: flip position s, then assert out_corrected. A parity-bit error still counts as corrected; data is unchanged.
  - s = 13..15: assert out_uncorrectable; no flip, raw data bits are extracted.
- Double errors that alias to s in 1..12 are miscorrected. This is accepted SEC-only behaviour and is not flagged.
- Pipeline:
  - Stage 1 registers the codeword and syndrome.
  - Stage 2 registers data, flags and syndrome to the outputs.
  - Latency is exactly 2 cycles from an accepted input to out_valid when out_ready is held high.
- Handshake:
  - adv = !out_valid || out_ready.
  - in_ready = adv, a combinational function of state and out_ready only, never of in_valid.
  - When adv is high, both stages shift: s1_valid <= in_valid, and out_valid <= s1_valid.
  - When adv is low, everything holds; out_* stay stable while out_valid && !out_ready.
  - A beat transfers on valid && ready. Full throughput is 1 beat/cycle with no bubbles.
- Counters:
  - Each counter increments by 1 when a valid stage-1 beat moves into stage 2 (adv && s1_valid) with the matching flag.
  - Counters saturate at 2^COUNT_W−1.
  - clr_counters forces both to 0 and wins over a same-cycle increment.
- Reset (asynchronous, any time, including mid-transfer):
  - out_valid=0, s1_valid=0, out_data=0, out_corrected=0, out_uncorrectable=0, out_syndrome=0, both counters=0.
  - In-flight beats are dropped.
  - in_ready reads 1 once rst deasserts, since out_valid=0.
- Data registers may be left unreset internally, but all out_* must read 0 while out_valid=0 after reset.

Decomposition:
- Package hamming_pkg holds the following:
  - DATA_W=8 and CW_W=12.
  - The position constants DATA_POS[0:7] = {3,5,6,7,9,10,11,12}.
  - A syndrome function and a data-extract function, shared with the encoder.
- One natural sub-module, hamming_correct_12: combinational syndrome, flip, extract and flags. The top holds the pipeline registers, handshake and counters.

Test Plan:
- Clean beat: in_codeword 0xA58 → 2 cycles later out_data 0xAA, syndrome 0, both flags 0. Also 0xF77 → 0xFF, clean.
- Data-bit error: 0xA78 (position 6 flipped) → out_data 0xAA, out_corrected=1, syndrome 6, cnt_corrected=1.
- Parity-bit error: 0xA59 (position 1 flipped) → out_data 0xAA, corrected=1, syndrome 1.
- Uncorrectable: 0x259 (positions 12 and 1 flipped) → syndrome 13, out_uncorrectable=1, out_data 0x2A, cnt_uncorrectable=1.
- Backpressure: stream 4 beats with out_ready low for 3 cycles mid-stream.
  - in_ready drops and out_* stay stable while stalled.
  - All 4 beats arrive in order with no loss or duplication.
  - Randomise out_ready over 200 beats against an encoder-model scoreboard.
- Reset and counters: assert rst with 2 beats in flight → out_valid=0 and counters=0 immediately, nothing emitted afterwards.
  - Then, with COUNT_W=2, send 5 corrected beats → cnt_corrected saturates at 3.
  - clr_counters together with an increment → 0.
